sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single-port SRAM between the AXI-Lite controller's write path and read path.
- Each path issues a level request with address and data. The arbiter grants one path, drives the SRAM strobes and waits for the matching done, then returns a one-cycle ack.
- Round-robin between the two paths when both request.
- Done-timeout watchdog so a hung SRAM never deadlocks the AXI side.

Parameters:
ADDR_W, 32, SRAM address width
DATA_W, 32, SRAM data width
TIMEOUT_CYCLES, 64, max busy cycles before forced error completion; 0 disables watchdog

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
wr_req  in  1  write path request (level)
wr_addr  in  ADDR_W  write address, stable while wr_req high
wr_data  in  DATA_W  write data, stable while wr_req high
wr_ack  out  1  one-cycle completion pulse for write
wr_err  out  1  valid with wr_ack; 1 = timed out
rd_req  in  1  read path request (level)
rd_addr  in  ADDR_W  read address, stable while rd_req high
rd_ack  out  1  one-cycle completion pulse for read
rd_data  out  DATA_W  read data, valid with rd_ack, held until next rd_ack
rd_err  out  1  valid with rd_ack; 1 = timed out
sram_addr  out  ADDR_W  SRAM address
sram_data_in  out  DATA_W  SRAM write data
wr_en  out  1  SRAM write strobe, held until done/timeout
rd_en  out  1  SRAM read strobe, held until done/timeout
sram_data_out  in  DATA_W  SRAM read data, valid with sram_read_done
sram_write_done  in  1  SRAM write complete pulse
sram_read_done  in  1  SRAM read complete pulse

Behaviour:
- Interface: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- All outputs are registered.
- Reset values: every output is 0, state = IDLE, priority pointer = WRITE, timeout counter = 0.
- States: IDLE, WR_BUSY, RD_BUSY, DONE.
- IDLE, sampling the requests:
  - Only wr_req high: capture wr_addr/wr_data into sram_addr/sram_data_in, set wr_en = 1, go to WR_BUSY.
  - Only rd_req high: capture rd_addr into sram_addr, set rd_en = 1, go to RD_BUSY.
  - Both high: grant the side named by the priority pointer.
  - Neither high: stay in IDLE.
  - Latency: request sampled at edge N gives the strobe high from edge N+1.
- WR_BUSY:
  - sram_write_done clears wr_en, pulses wr_ack (wr_err = 0) at the next edge, and moves to DONE.
  - sram_read_done is ignored in this state.
- RD_BUSY:
  - sram_read_done latches sram_data_out into rd_data, clears rd_en, pulses rd_ack (rd_err = 0), and moves to DONE.
  - sram_write_done is ignored in this state.
- Timeout:
  - The counter clears on entering a BUSY state and increments each BUSY cycle.
  - When the count equals TIMEOUT_CYCLES with no done: drop the strobe, pulse ack with err = 1, move to DONE. On a read timeout, rd_data = 0.
  - A done arriving on the timeout cycle wins: normal completion, err = 0.
- DONE:
  - Lasts exactly one cycle; ack/err are high during it.
  - Requests are not sampled in DONE.
  - The priority pointer flips to the side that did not just complete.
  - Next state is IDLE.
- Requester rule:
  - A requester deasserts req on the edge at which it samples ack.
  - A req still high in IDLE after DONE is a new request.
- Back-to-back throughput: at most one access per 3 + SRAM-latency cycles.
- Strobes are mutually exclusive: wr_en and rd_en are never high together.
- sram_addr and sram_data_in hold stable for the whole BUSY period.
- Stray done pulses seen in IDLE or DONE are ignored.
- Reset mid-access: strobes drop immediately (async), no ack is issued, and the pointer returns to WRITE.

Decomposition:
- Shared package `sram_arb_pkg`:
  - state enum `arb_state_t` {IDLE, WR_BUSY, RD_BUSY, DONE}
  - grant enum `arb_grant_t` {GNT_WR, GNT_RD}
  - default width constants
- Optional sub-module `sram_arb_rr2`: two-input round-robin picker with a registered pointer and an update-enable input. The timeout counter stays inline.

Test Plan:
- Write only: wr_req, addr 0x10, data 0xDEADBEEF; done 2 cycles after wr_en -> wr_en high for 3 cycles with sram_addr = 0x10 and sram_data_in = 0xDEADBEEF; wr_ack one pulse, wr_err = 0.
- Read only: rd_req, addr 0x20; SRAM returns 0xCAFEF00D with sram_read_done -> rd_ack pulse, rd_data = 0xCAFEF00D, rd_en never overlaps wr_en.
- Simultaneous wr_req and rd_req, both held for 4 accesses -> grant order W, R, W, R; each ack followed by DONE then IDLE.
- TIMEOUT_CYCLES = 8, SRAM never returns done on a read -> rd_en high 8 cycles, rd_ack with rd_err = 1, rd_data = 0; a subsequent write completes normally.
- rst_n low mid WR_BUSY, then released -> wr_en = 0 asynchronously, no wr_ack, and a fresh dual request is granted to write first.
- Stray sram_read_done during WR_BUSY -> ignored; completion occurs only on sram_write_done.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-path SRAM port arbiter.
package sram_arb_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } arb_grant_t;

  function automatic arb_grant_t other_side(input arb_grant_t g);
    return (g == GNT_WR) ? GNT_RD : GNT_WR;
  endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-input round-robin picker; the pointer names the side that wins a tie.
module sram_arb_rr2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_wr_i,
  input  logic       req_rd_i,
  input  logic       upd_i,
  input  arb_grant_t done_side_i,
  output logic       gnt_valid_o,
  output arb_grant_t gnt_o
);

  arb_grant_t ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = other_side(done_side_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= GNT_WR;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_valid_o = req_wr_i | req_rd_i;
    gnt_o       = ptr_q;
    if (req_wr_i && !req_rd_i)      gnt_o = GNT_WR;
    else if (!req_wr_i && req_rd_i) gnt_o = GNT_RD;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between a write path and a read path, with
// round-robin on ties and a done-timeout watchdog.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_data_in,
  output logic              wr_en,
  output logic              rd_en,
  input  logic [DATA_W-1:0] sram_data_out,
  input  logic              sram_write_done,
  input  logic              sram_read_done,
  output arb_state_t        dbg_state_o
);

  // cnt_q holds the number of busy cycles already elapsed before the current one.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
  logic              wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic              wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
  logic              rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
  logic              gnt_valid, timeout_hit;
  arb_grant_t        gnt;

  sram_arb_rr2 u_rr (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_wr_i   (wr_req),
    .req_rd_i   (rd_req),
    .upd_i      (state_q == DONE),
    .done_side_i(wr_ack_q ? GNT_WR : GNT_RD),
    .gnt_valid_o(gnt_valid),
    .gnt_o      (gnt)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    wr_en_d   = wr_en_q;
    rd_en_d   = rd_en_q;
    wr_ack_d  = 1'b0;
    wr_err_d  = 1'b0;
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          cnt_d = '0;
          if (gnt == GNT_WR) begin
            addr_d  = wr_addr;
            wdata_d = wr_data;
            wr_en_d = 1'b1;
            state_d = WR_BUSY;
          end else begin
            addr_d  = rd_addr;
            rd_en_d = 1'b1;
            state_d = RD_BUSY;
          end
        end
      end
      WR_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // A done on the timeout cycle still counts as a clean completion.
        if (sram_write_done || timeout_hit) begin
          wr_en_d  = 1'b0;
          wr_ack_d = 1'b1;
          wr_err_d = ~sram_write_done;
          state_d  = DONE;
        end
      end
      RD_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (sram_read_done || timeout_hit) begin
          rd_en_d   = 1'b0;
          rd_ack_d  = 1'b1;
          rd_err_d  = ~sram_read_done;
          rd_data_d = sram_read_done ? sram_data_out : '0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign sram_addr    = addr_q;
  assign sram_data_in = wdata_q;
  assign wr_en        = wr_en_q;
  assign rd_en        = rd_en_q;
  assign wr_ack       = wr_ack_q;
  assign wr_err       = wr_err_q;
  assign rd_ack       = rd_ack_q;
  assign rd_err       = rd_err_q;
  assign rd_data      = rd_data_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM responder and a completion scoreboard.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk, rst_n;
  logic          wr_req, rd_req;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr;
  logic [DW-1:0] wr_data, rd_data, sram_data_in, sram_data_out;
  logic          wr_ack, wr_err, rd_ack, rd_err, wr_en, rd_en;
  logic          sram_write_done, sram_read_done;
  arb_state_t    dbg_state;

  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .wr_err         (wr_err),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_ack         (rd_ack),
    .rd_data        (rd_data),
    .rd_err         (rd_err),
    .sram_addr      (sram_addr),
    .sram_data_in   (sram_data_in),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .sram_data_out  (sram_data_out),
    .sram_write_done(sram_write_done),
    .sram_read_done (sram_read_done),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int            n_cmp = 0;
  int            n_err = 0;
  logic [33:0]   exp_q[$];
  int            wr_left, rd_left;
  int            last_stb, last_lat;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  logic [7:0]    order;
  int            resp_lat;
  bit            resp_hang, stray_rd;
  logic [DW-1:0] rd_resp_data, seen_wdata, wd, rd_exp;
  int            busy_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_compare();
    logic [33:0] got, exp;
    got = wr_ack ? {1'b0, wr_err, seen_wdata} : {1'b1, rd_err, rd_data};
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL sb_unexpected_ack: observed %0h expected none", got);
    end else begin
      exp = exp_q.pop_front();
      check("sb_completion", 64'(got), 64'(exp));
    end
  endtask

  // ---------------- SRAM responder ----------------
  initial begin
    sram_write_done = 1'b0;
    sram_read_done  = 1'b0;
    sram_data_out   = '0;
    seen_wdata      = '0;
    busy_cnt        = 0;
    forever begin
      @(posedge clk); #1;
      sram_write_done = 1'b0;
      sram_read_done  = 1'b0;
      if (!rst_n || !(wr_en || rd_en)) busy_cnt = 0;
      else begin
        if (stray_rd && wr_en && busy_cnt == 0) begin
          sram_read_done = 1'b1;
          sram_data_out  = 32'hBAD0BAD0;
        end
        if (!resp_hang && busy_cnt == resp_lat) begin
          if (wr_en) begin
            sram_write_done = 1'b1;
            seen_wdata      = sram_data_in;
          end else begin
            sram_read_done = 1'b1;
            sram_data_out  = rd_resp_data;
          end
        end
        busy_cnt++;
      end
    end
  end

  // Strobes and acks must never overlap.
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl", 64'(wr_en & rd_en), 64'd0);
      check("ack_excl", 64'(wr_ack & rd_ack), 64'd0);
    end
  end

  // ---------------- driver: collect n completions ----------------
  task automatic wait_acks(input int n);
    int got, cyc, stb;
    bit stable;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    got = 0; cyc = 0; stb = 0; stable = 1'b1; a0 = '0; d0 = '0;
    last_lat = -1;
    while (got < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (wr_en || rd_en) begin
        if (stb == 0) begin
          a0 = sram_addr;
          d0 = sram_data_in;
          if (last_lat < 0) last_lat = cyc;
        end else if (sram_addr !== a0 || (wr_en && sram_data_in !== d0)) stable = 1'b0;
        stb++;
      end
      if (wr_ack || rd_ack) begin
        got++;
        last_stb  = stb;
        last_addr = a0;
        last_din  = d0;
        stb = 0;
        check("ack_in_done", 64'(dbg_state), 64'(DONE));
        check("busy_stable", 64'(stable), 64'd1);
        stable = 1'b1;
        sb_compare();
        order = {order[6:0], rd_ack};
        if (wr_ack) begin wr_left--; if (wr_left == 0) wr_req = 1'b0; end
        if (rd_ack) begin rd_left--; if (rd_left == 0) rd_req = 1'b0; end
        @(negedge clk);
        cyc++;
        check("ack_one_cycle", 64'({wr_ack, rd_ack}), 64'd0);
        check("done_to_idle", 64'(dbg_state), 64'(IDLE));
      end
    end
    if (got < n) check("ack_budget", 64'(got), 64'(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    resp_lat = 2; resp_hang = 1'b0; stray_rd = 1'b0;
    rd_resp_data = '0; order = '0; wr_left = 0; rd_left = 0;
    last_stb = 0; last_lat = 0; last_addr = '0; last_din = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({wr_en, rd_en, wr_ack, wr_err, rd_ack, rd_err}), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_din", 64'(sram_data_in), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Write only
    wr_addr = 32'h10; wr_data = 32'hDEADBEEF; wr_left = 1; wr_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    wait_acks(1);
    check("wr_latency", 64'(last_lat), 64'd1);
    check("wr_stb_cycles", 64'(last_stb), 64'd3);
    check("wr_addr", 64'(last_addr), 64'h10);
    check("wr_din", 64'(last_din), 64'hDEADBEEF);

    // Read only
    rd_addr = 32'h20; rd_resp_data = 32'hCAFEF00D; rd_left = 1; rd_req = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 32'hCAFEF00D});
    wait_acks(1);
    check("rd_addr", 64'(last_addr), 64'h20);
    @(negedge clk);
    check("rd_data_hold", 64'(rd_data), 64'hCAFEF00D);

    // Both held for four accesses: W, R, W, R
    wd = $urandom; rd_resp_data = $urandom;
    wr_addr = 32'($urandom_range(0, 255)); rd_addr = 32'($urandom_range(256, 511));
    wr_data = wd; wr_left = 2; rd_left = 2;
    wr_req = 1'b1; rd_req = 1'b1;
    repeat (2) begin
      exp_q.push_back({1'b0, 1'b0, wd});
      exp_q.push_back({1'b1, 1'b0, rd_resp_data});
    end
    wait_acks(4);
    check("rr_order", 64'(order[3:0]), 64'b0101);
    check("rr_reqs_dropped", 64'({wr_req, rd_req}), 64'd0);

    // Read timeout, then a normal write
    resp_hang = 1'b1; rd_addr = 32'h30; rd_resp_data = 32'h55AA55AA;
    rd_left = 1; rd_req = 1'b1;
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    wait_acks(1);
    check("to_stb_cycles", 64'(last_stb), 64'(TO));
    resp_hang = 1'b0;
    wd = $urandom; wr_addr = 32'h34; wr_data = wd; wr_left = 1; wr_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, wd});
    wait_acks(1);
    check("post_to_wr_stb", 64'(last_stb), 64'd3);
    check("rd_data_zero_hold", 64'(rd_data), 64'd0);

    // Reset in the middle of a write (pointer currently favours read)
    resp_hang = 1'b1; wr_addr = 32'h50; wr_data = 32'h0BADF00D; wr_req = 1'b1;
    for (int i = 0; i < 20 && !wr_en; i++) @(negedge clk);
    check("rst_mid_busy", 64'(wr_en), 64'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wr_en", 64'(wr_en), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'(IDLE));
    wr_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_mid_no_ack", 64'(wr_ack), 64'd0);
    end
    rst_n = 1'b1; resp_hang = 1'b0;
    @(negedge clk);
    check("rst_rel_no_ack", 64'(wr_ack), 64'd0);
    wd = $urandom; rd_exp = $urandom; rd_resp_data = rd_exp;
    wr_addr = 32'h60; wr_data = wd; rd_addr = 32'h64;
    wr_left = 1; rd_left = 1; wr_req = 1'b1; rd_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, wd});
    exp_q.push_back({1'b1, 1'b0, rd_exp});
    wait_acks(2);
    check("rst_rr_order", 64'(order[1:0]), 64'b01);

    // Stray read done during a write
    stray_rd = 1'b1; resp_lat = 3;
    wr_addr = 32'h70; wr_data = 32'h12345678; wr_left = 1; wr_req = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h12345678});
    wait_acks(1);
    stray_rd = 1'b0;
    check("stray_stb_cycles", 64'(last_stb), 64'd4);
    check("stray_rd_data", 64'(rd_data), 64'(rd_exp));
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
